// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants and the {pc, instr} entry layout used by the fetch queue.
package fetch_queue_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Purpose: DEPTH x {pc,instr} register file, one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates writes.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fq_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output fq_entry_t       rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Purpose: captures {F_PC, imem word} into a small FIFO and hands the head to decode.
// Latency: a pushed entry reaches the head one cycle later.
// Backpressure: PC_en drops while full; no same-cycle pop->push bypass.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     F_PC,
    output logic            PC_en,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            flush,
    input  logic            D_ready,
    output logic            D_valid,
    output logic [31:0]     D_instr,
    output logic [31:0]     D_pc,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    fq_entry_t     wr_entry;
    fq_entry_t     head;

    assign imem_addr = F_PC;
    assign D_valid   = (count != '0);
    assign push      = !reset && !flush && (count != FULL);
    // A flush lets the PC load its redirect target even though nothing is pushed.
    assign PC_en     = push || (flush && !reset);
    assign pop       = D_valid && D_ready && !flush;
    assign wr_entry  = '{pc: F_PC, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign D_instr = D_valid ? head.instr : NOP_INSTR;
    assign D_pc    = D_valid ? head.pc    : 32'h0;

endmodule
